exc_flush_ctrl: RTL and testbench
=================================

EXC_FLUSH_CTRL -- requirements
Module: exc_flush_ctrl

Interface
REQ-001 SHALL have parameter VEC_BEV_BASE, default 32'hBFC00200; the boot-time (Status.BEV=1) exception vector base.
REQ-002 SHALL have parameter VEC_NRM_BASE, default 32'h80000000; the normal (BEV=0) exception vector base.
REQ-003 SHALL have port clk, input, 1; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; synchronous, active-high reset.
REQ-005 SHALL have ports exc_flag (in, 1), exc_type (in, 5), exc_baddr (in, 32), exc_save (in, 1), exc_pc (in, 32), exc_bd (in, 1, delay slot), exc_store (in, 1); the prioritised exception report from the exception unit.
REQ-006 SHALL have ports cp0_status (in, 32), cp0_cause (in, 32), cp0_epc (in, 32), cp0_errorepc (in, 32).
REQ-007 SHALL have port mem_busy, input, 1; the data-bus transaction is outstanding.
REQ-008 SHALL have port fetch_ready, input, 1; the fetch stage accepts a redirect.
REQ-009 SHALL have output stall (1), flush (1), redirect_valid (1), redirect_pc (32).
REQ-010 SHALL have output cp0_exc_we (1), cp0_exccode (5), cp0_epc_o (32), cp0_bd (1), cp0_badv_we (1), cp0_badv (32), cp0_eret (1).

Function
REQ-011 SHALL implement FSM states IDLE, DRAIN, COMMIT, REDIRECT.
REQ-012 IDLE: if exc_flag=1 and mem_busy=0, SHALL latch the exception fields and go to COMMIT; if exc_flag=1 and mem_busy=1, SHALL latch the fields and go to DRAIN; otherwise SHALL remain in IDLE.
REQ-013 DRAIN: SHALL assert stall=1 and stay until mem_busy=0, then go to COMMIT.
REQ-014 COMMIT: exactly one cycle; flush=1; for non-ERET, cp0_exc_we=1 with cp0_exccode, cp0_epc_o (exc_pc-4 if exc_bd=1, else exc_pc) and cp0_bd; cp0_badv_we=exc_save, cp0_badv=exc_baddr; for ERET, cp0_eret=1 and cp0_exc_we=0; then go to REDIRECT.
REQ-015 REDIRECT: SHALL hold flush=1, redirect_valid=1, stable redirect_pc; on fetch_ready=1, SHALL go to IDLE next cycle.
REQ-016 ExcCode map: Intr 0, TLBM 1, TLBR/TLBI 2 (load) or 3 (exc_store=1), AdEL 4, AdES 5, SysC 8, Bp 9, RI 10, CpU 11, Ov 12, Trap 13.
REQ-017 Vector: base = BEV ? VEC_BEV_BASE : VEC_NRM_BASE; offset 0x000 for TLBR with Status.EXL=0, else 0x180; sampled at the latch cycle.
REQ-018 ERET: redirect_pc = Status.ERL ? cp0_errorepc : cp0_epc, sampled at the latch cycle.
REQ-019 Latency from exc_flag to redirect_valid, with mem_busy=0: 2 cycles.
REQ-020 exc_flag SHALL be ignored in all states except IDLE; no queueing.
REQ-021 exc_type NoExc with exc_flag=1 SHALL be treated as no exception and remain in IDLE.
REQ-022 stall SHALL be 1 in DRAIN, COMMIT and REDIRECT.

Reset
REQ-023 On rst=1, SHALL go to IDLE and set every output to 0, including redirect_pc=32'h0 and all latched fields; this applies in any state, including mid-DRAIN and mid-REDIRECT.

Configuration
REQ-024 With EXC_VEC_IV_EN defined, Intr with Cause.IV=1 and BEV=0 SHALL use offset 0x200; without it, Intr SHALL always use offset 0x180 and Cause.IV is ignored.

Structure
REQ-025 ExcType encodings, ExcCode values, vector offsets and FSM state encodings SHALL reside in the shared defines package, alongside the existing ExcT_* constants.
REQ-026 Vector/redirect-PC computation SHALL be a combinational sub-module exc_vec_gen.

Verification
REQ-027 SysC at exc_pc=0x80001000, BEV=0, mem_busy=0 -> COMMIT next cycle with exccode=8 and epc=0x80001000; redirect_pc=0x80000180 one cycle later.
REQ-028 AdEL with exc_bd=1, exc_pc=0x80002004, exc_baddr=0x13, exc_save=1 -> epc=0x80002000, bd=1, badv_we=1, badv=0x13.
REQ-029 TLBR with exc_store=1, EXL=0, BEV=1 -> exccode=3, redirect_pc=0xBFC00200; repeated with EXL=1 -> redirect_pc=0xBFC00380.
REQ-030 ERET with ERL=0, cp0_epc=0x80004000, mem_busy=1 for 3 cycles -> stall for 3 DRAIN cycles, cp0_eret pulse, redirect_pc=0x80004000.
REQ-031 fetch_ready held 0 for 4 cycles in REDIRECT -> redirect_valid and redirect_pc stable; a second exc_flag during that time is ignored.
REQ-032 rst asserted in DRAIN -> next cycle IDLE, all outputs 0; with EXC_VEC_IV_EN defined, Intr with IV=1 -> redirect_pc=0x80000200.

Source files
------------

// File: rtl/exc_flush_ctrl_pkg.sv
// Shared defines for the exception flush controller: ExcType encodings, ExcCodes,
// vector offsets, CP0 bit positions and FSM states.
package exc_flush_ctrl_pkg;

  localparam logic [4:0] ExcT_NoExc = 5'd0;
  localparam logic [4:0] ExcT_Intr  = 5'd1;
  localparam logic [4:0] ExcT_TLBM  = 5'd2;
  localparam logic [4:0] ExcT_TLBR  = 5'd3;
  localparam logic [4:0] ExcT_TLBI  = 5'd4;
  localparam logic [4:0] ExcT_AdEL  = 5'd5;
  localparam logic [4:0] ExcT_AdES  = 5'd6;
  localparam logic [4:0] ExcT_SysC  = 5'd7;
  localparam logic [4:0] ExcT_Bp    = 5'd8;
  localparam logic [4:0] ExcT_RI    = 5'd9;
  localparam logic [4:0] ExcT_CpU   = 5'd10;
  localparam logic [4:0] ExcT_Ov    = 5'd11;
  localparam logic [4:0] ExcT_Trap  = 5'd12;
  localparam logic [4:0] ExcT_ERET  = 5'd13;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_MOD  = 5'd1;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_CPU  = 5'd11;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TR   = 5'd13;

  localparam logic [31:0] VEC_OFF_TLBR = 32'h0000_0000;
  localparam logic [31:0] VEC_OFF_GEN  = 32'h0000_0180;
  localparam logic [31:0] VEC_OFF_IV   = 32'h0000_0200;

  localparam int STATUS_EXL = 1;
  localparam int STATUS_ERL = 2;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_IV   = 23;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } exc_state_e;

  // Unassigned encodings are dropped the same way as NoExc.
  function automatic logic exc_is_valid(input logic [4:0] t);
    return (t != ExcT_NoExc) && (t <= ExcT_ERET);
  endfunction

  function automatic logic [4:0] exc_code(input logic [4:0] t, input logic store);
    logic [4:0] code;
    code = EXCCODE_INT;
    case (t)
      ExcT_TLBM:             code = EXCCODE_MOD;
      ExcT_TLBR, ExcT_TLBI:  code = store ? EXCCODE_TLBS : EXCCODE_TLBL;
      ExcT_AdEL:             code = EXCCODE_ADEL;
      ExcT_AdES:             code = EXCCODE_ADES;
      ExcT_SysC:             code = EXCCODE_SYS;
      ExcT_Bp:               code = EXCCODE_BP;
      ExcT_RI:               code = EXCCODE_RI;
      ExcT_CpU:              code = EXCCODE_CPU;
      ExcT_Ov:               code = EXCCODE_OV;
      ExcT_Trap:             code = EXCCODE_TR;
      default:               code = EXCCODE_INT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/exc_vec_gen.sv
// Combinational redirect target: exception vector or ERET return address.
// Interrupt vectoring (Cause.IV) is only honoured when EXC_VEC_IV_EN is defined.
module exc_vec_gen
  import exc_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BEV_BASE = 32'hBFC0_0200,
  parameter logic [31:0] VEC_NRM_BASE = 32'h8000_0000
) (
  input  logic [4:0]  exc_type,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_errorepc,
  output logic [31:0] target_pc
);

  logic        bev;
  logic        iv_take;
  logic        unused_bits;
  logic [31:0] base;
  logic [31:0] offset;

  assign bev = cp0_status[STATUS_BEV];

`ifdef EXC_VEC_IV_EN
  assign iv_take     = (exc_type == ExcT_Intr) && cp0_cause[CAUSE_IV] && !bev;
  assign unused_bits = ^{cp0_status[31:23], cp0_status[21:3], cp0_status[0],
                         cp0_cause[31:24], cp0_cause[22:0]};
`else
  assign iv_take     = 1'b0;
  assign unused_bits = ^{cp0_status[31:23], cp0_status[21:3], cp0_status[0], cp0_cause};
`endif

  always_comb begin
    base = bev ? VEC_BEV_BASE : VEC_NRM_BASE;
    if ((exc_type == ExcT_TLBR) && !cp0_status[STATUS_EXL]) begin
      offset = VEC_OFF_TLBR;
    end else if (iv_take) begin
      offset = VEC_OFF_IV;
    end else begin
      offset = VEC_OFF_GEN;
    end
    if (exc_type == ExcT_ERET) begin
      target_pc = cp0_status[STATUS_ERL] ? cp0_errorepc : cp0_epc;
    end else begin
      target_pc = base + offset;
    end
  end

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception/ERET flush controller: drains the data bus, commits CP0 state for one
// cycle, then holds a redirect until fetch accepts it. Optional: EXC_VEC_IV_EN.
module exc_flush_ctrl
  import exc_flush_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BEV_BASE = 32'hBFC0_0200,
  parameter logic [31:0] VEC_NRM_BASE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_flag,
  input  logic [4:0]  exc_type,
  input  logic [31:0] exc_baddr,
  input  logic        exc_save,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_store,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [31:0] cp0_errorepc,
  input  logic        mem_busy,
  input  logic        fetch_ready,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic [4:0]  cp0_exccode,
  output logic [31:0] cp0_epc_o,
  output logic        cp0_bd,
  output logic        cp0_badv_we,
  output logic [31:0] cp0_badv,
  output logic        cp0_eret
);

  exc_state_e  state_q, state_d;
  logic        lat_eret_q, lat_eret_d;
  logic [4:0]  lat_code_q, lat_code_d;
  logic [31:0] lat_epc_q, lat_epc_d;
  logic        lat_bd_q, lat_bd_d;
  logic        lat_badv_we_q, lat_badv_we_d;
  logic [31:0] lat_badv_q, lat_badv_d;
  logic [31:0] lat_target_q, lat_target_d;

  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        cp0_exc_we_q, cp0_exc_we_d;
  logic [4:0]  cp0_exccode_q, cp0_exccode_d;
  logic [31:0] cp0_epc_o_q, cp0_epc_o_d;
  logic        cp0_bd_q, cp0_bd_d;
  logic        cp0_badv_we_q, cp0_badv_we_d;
  logic [31:0] cp0_badv_q, cp0_badv_d;
  logic        cp0_eret_q, cp0_eret_d;

  logic [31:0] vec_target;

  exc_vec_gen #(
    .VEC_BEV_BASE(VEC_BEV_BASE),
    .VEC_NRM_BASE(VEC_NRM_BASE)
  ) u_vec_gen (
    .exc_type    (exc_type),
    .cp0_status  (cp0_status),
    .cp0_cause   (cp0_cause),
    .cp0_epc     (cp0_epc),
    .cp0_errorepc(cp0_errorepc),
    .target_pc   (vec_target)
  );

  // Outputs are decoded from the next state so they line up with the registered state.
  always_comb begin
    state_d       = state_q;
    lat_eret_d    = lat_eret_q;
    lat_code_d    = lat_code_q;
    lat_epc_d     = lat_epc_q;
    lat_bd_d      = lat_bd_q;
    lat_badv_we_d = lat_badv_we_q;
    lat_badv_d    = lat_badv_q;
    lat_target_d  = lat_target_q;

    case (state_q)
      ST_IDLE: begin
        if (exc_flag && exc_is_valid(exc_type)) begin
          lat_eret_d    = (exc_type == ExcT_ERET);
          lat_code_d    = exc_code(exc_type, exc_store);
          lat_epc_d     = exc_bd ? (exc_pc - 32'd4) : exc_pc;
          lat_bd_d      = exc_bd;
          lat_badv_we_d = exc_save;
          lat_badv_d    = exc_baddr;
          lat_target_d  = vec_target;
          state_d       = mem_busy ? ST_DRAIN : ST_COMMIT;
        end
      end
      ST_DRAIN:    if (!mem_busy) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: if (fetch_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    stall_d          = (state_d != ST_IDLE);
    flush_d          = (state_d == ST_COMMIT) || (state_d == ST_REDIRECT);
    redirect_valid_d = (state_d == ST_REDIRECT);
    redirect_pc_d    = (state_d == ST_REDIRECT) ? lat_target_d : 32'h0;
    cp0_exc_we_d     = 1'b0;
    cp0_exccode_d    = 5'd0;
    cp0_epc_o_d      = 32'h0;
    cp0_bd_d         = 1'b0;
    cp0_badv_we_d    = 1'b0;
    cp0_badv_d       = 32'h0;
    cp0_eret_d       = 1'b0;
    if (state_d == ST_COMMIT) begin
      cp0_eret_d = lat_eret_d;
      if (!lat_eret_d) begin
        cp0_exc_we_d  = 1'b1;
        cp0_exccode_d = lat_code_d;
        cp0_epc_o_d   = lat_epc_d;
        cp0_bd_d      = lat_bd_d;
        cp0_badv_we_d = lat_badv_we_d;
        cp0_badv_d    = lat_badv_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      lat_eret_q       <= 1'b0;
      lat_code_q       <= 5'd0;
      lat_epc_q        <= 32'h0;
      lat_bd_q         <= 1'b0;
      lat_badv_we_q    <= 1'b0;
      lat_badv_q       <= 32'h0;
      lat_target_q     <= 32'h0;
      stall_q          <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      cp0_exc_we_q     <= 1'b0;
      cp0_exccode_q    <= 5'd0;
      cp0_epc_o_q      <= 32'h0;
      cp0_bd_q         <= 1'b0;
      cp0_badv_we_q    <= 1'b0;
      cp0_badv_q       <= 32'h0;
      cp0_eret_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      lat_eret_q       <= lat_eret_d;
      lat_code_q       <= lat_code_d;
      lat_epc_q        <= lat_epc_d;
      lat_bd_q         <= lat_bd_d;
      lat_badv_we_q    <= lat_badv_we_d;
      lat_badv_q       <= lat_badv_d;
      lat_target_q     <= lat_target_d;
      stall_q          <= stall_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      cp0_exc_we_q     <= cp0_exc_we_d;
      cp0_exccode_q    <= cp0_exccode_d;
      cp0_epc_o_q      <= cp0_epc_o_d;
      cp0_bd_q         <= cp0_bd_d;
      cp0_badv_we_q    <= cp0_badv_we_d;
      cp0_badv_q       <= cp0_badv_d;
      cp0_eret_q       <= cp0_eret_d;
    end
  end

  assign stall          = stall_q;
  assign flush          = flush_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign cp0_exc_we     = cp0_exc_we_q;
  assign cp0_exccode    = cp0_exccode_q;
  assign cp0_epc_o      = cp0_epc_o_q;
  assign cp0_bd         = cp0_bd_q;
  assign cp0_badv_we    = cp0_badv_we_q;
  assign cp0_badv       = cp0_badv_q;
  assign cp0_eret       = cp0_eret_q;

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed self-checking bench for exc_flush_ctrl; expected values are hand-computed.
// The interrupt-vector expectation follows EXC_VEC_IV_EN.
module tb_exc_flush_ctrl;
  import exc_flush_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_flag, exc_save, exc_bd, exc_store, mem_busy, fetch_ready;
  logic [4:0]  exc_type;
  logic [31:0] exc_baddr, exc_pc, cp0_status, cp0_cause, cp0_epc, cp0_errorepc;
  logic        stall, flush, redirect_valid, cp0_exc_we, cp0_bd, cp0_badv_we, cp0_eret;
  logic [31:0] redirect_pc, cp0_epc_o, cp0_badv;
  logic [4:0]  cp0_exccode;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] iv_expect;

  exc_flush_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_flag(exc_flag), .exc_type(exc_type), .exc_baddr(exc_baddr), .exc_save(exc_save),
    .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_store(exc_store),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .cp0_errorepc(cp0_errorepc), .mem_busy(mem_busy), .fetch_ready(fetch_ready),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .cp0_exc_we(cp0_exc_we), .cp0_exccode(cp0_exccode), .cp0_epc_o(cp0_epc_o),
    .cp0_bd(cp0_bd), .cp0_badv_we(cp0_badv_we), .cp0_badv(cp0_badv), .cp0_eret(cp0_eret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic flag, input logic [4:0] typ, input logic [31:0] pc,
                               input logic bd, input logic store, input logic save,
                               input logic [31:0] baddr);
    exc_flag  = flag;
    exc_type  = typ;
    exc_pc    = pc;
    exc_bd    = bd;
    exc_store = store;
    exc_save  = save;
    exc_baddr = baddr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic finishRedirect();
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0; cp0_errorepc = 32'h0;
    mem_busy = 1'b0; fetch_ready = 1'b0;
    tick(); tick();
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    checkOutput("reset_flush", {31'b0, flush}, 32'h0);
    checkOutput("reset_rv", {31'b0, redirect_valid}, 32'h0);
    checkOutput("reset_rpc", redirect_pc, 32'h0);
    rst = 1'b0;
    tick();

    // SysC, no bus activity: COMMIT next cycle, redirect one cycle later.
    applyStimulus(1'b1, ExcT_SysC, 32'h8000_1000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("sysc_flush", {31'b0, flush}, 32'h1);
    checkOutput("sysc_stall", {31'b0, stall}, 32'h1);
    checkOutput("sysc_we", {31'b0, cp0_exc_we}, 32'h1);
    checkOutput("sysc_code", {27'b0, cp0_exccode}, 32'd8);
    checkOutput("sysc_epc", cp0_epc_o, 32'h8000_1000);
    checkOutput("sysc_rv_early", {31'b0, redirect_valid}, 32'h0);
    tick();
    checkOutput("sysc_rv", {31'b0, redirect_valid}, 32'h1);
    checkOutput("sysc_rpc", redirect_pc, 32'h8000_0180);
    checkOutput("sysc_we_drop", {31'b0, cp0_exc_we}, 32'h0);
    finishRedirect();
    checkOutput("sysc_idle_rv", {31'b0, redirect_valid}, 32'h0);
    checkOutput("sysc_idle_stall", {31'b0, stall}, 32'h0);

    // AdEL in a delay slot with a bad address to save.
    applyStimulus(1'b1, ExcT_AdEL, 32'h8000_2004, 1'b1, 1'b0, 1'b1, 32'h13);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("adel_code", {27'b0, cp0_exccode}, 32'd4);
    checkOutput("adel_epc", cp0_epc_o, 32'h8000_2000);
    checkOutput("adel_bd", {31'b0, cp0_bd}, 32'h1);
    checkOutput("adel_badv_we", {31'b0, cp0_badv_we}, 32'h1);
    checkOutput("adel_badv", cp0_badv, 32'h13);
    tick();
    checkOutput("adel_rpc", redirect_pc, 32'h8000_0180);
    finishRedirect();

    // TLB refill on a store with BEV=1, first EXL=0 then EXL=1.
    cp0_status = 32'h0040_0000;
    applyStimulus(1'b1, ExcT_TLBR, 32'h8000_3000, 1'b0, 1'b1, 1'b1, 32'h4000);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("tlbr_code", {27'b0, cp0_exccode}, 32'd3);
    tick();
    checkOutput("tlbr_rpc_exl0", redirect_pc, 32'hBFC0_0200);
    finishRedirect();
    cp0_status = 32'h0040_0002;
    applyStimulus(1'b1, ExcT_TLBR, 32'h8000_3000, 1'b0, 1'b1, 1'b1, 32'h4000);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("tlbr_code_exl1", {27'b0, cp0_exccode}, 32'd3);
    tick();
    checkOutput("tlbr_rpc_exl1", redirect_pc, 32'hBFC0_0380);
    finishRedirect();

    // ERET behind a 3-cycle bus transaction; cp0_epc changes after latching.
    cp0_status = 32'h0;
    cp0_epc = 32'h8000_4000;
    mem_busy = 1'b1;
    applyStimulus(1'b1, ExcT_ERET, 32'h8000_5000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    cp0_epc = 32'h1234_5678;
    checkOutput("eret_drain1_stall", {31'b0, stall}, 32'h1);
    checkOutput("eret_drain1_flush", {31'b0, flush}, 32'h0);
    tick();
    checkOutput("eret_drain2_stall", {31'b0, stall}, 32'h1);
    tick();
    mem_busy = 1'b0;
    checkOutput("eret_drain3_stall", {31'b0, stall}, 32'h1);
    checkOutput("eret_drain3_eret", {31'b0, cp0_eret}, 32'h0);
    tick();
    checkOutput("eret_commit_eret", {31'b0, cp0_eret}, 32'h1);
    checkOutput("eret_commit_we", {31'b0, cp0_exc_we}, 32'h0);
    checkOutput("eret_commit_flush", {31'b0, flush}, 32'h1);
    tick();
    checkOutput("eret_rpc", redirect_pc, 32'h8000_4000);
    checkOutput("eret_pulse_end", {31'b0, cp0_eret}, 32'h0);

    // Hold the redirect for 4 cycles while a new exception is offered.
    applyStimulus(1'b1, ExcT_SysC, 32'h8000_6000, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("hold_rv", {31'b0, redirect_valid}, 32'h1);
      checkOutput("hold_rpc", redirect_pc, 32'h8000_4000);
      checkOutput("hold_we", {31'b0, cp0_exc_we}, 32'h0);
    end
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    finishRedirect();
    checkOutput("hold_exit_rv", {31'b0, redirect_valid}, 32'h0);
    tick();
    checkOutput("hold_no_queue_stall", {31'b0, stall}, 32'h0);
    checkOutput("hold_no_queue_we", {31'b0, cp0_exc_we}, 32'h0);

    // NoExc with the flag set stays idle.
    applyStimulus(1'b1, ExcT_NoExc, 32'h8000_7000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("noexc_stall", {31'b0, stall}, 32'h0);
    checkOutput("noexc_flush", {31'b0, flush}, 32'h0);

    // Reset while draining.
    mem_busy = 1'b1;
    applyStimulus(1'b1, ExcT_SysC, 32'h8000_8000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstdrain_pre_stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_busy = 1'b0;
    checkOutput("rstdrain_stall", {31'b0, stall}, 32'h0);
    checkOutput("rstdrain_rpc", redirect_pc, 32'h0);
    tick();
    checkOutput("rstdrain_idle_stall", {31'b0, stall}, 32'h0);
    checkOutput("rstdrain_idle_we", {31'b0, cp0_exc_we}, 32'h0);

    // Reset while redirecting.
    applyStimulus(1'b1, ExcT_Bp, 32'h8000_9000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("bp_code", {27'b0, cp0_exccode}, 32'd9);
    tick();
    checkOutput("rstredir_pre_rv", {31'b0, redirect_valid}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstredir_rv", {31'b0, redirect_valid}, 32'h0);
    checkOutput("rstredir_rpc", redirect_pc, 32'h0);
    checkOutput("rstredir_flush", {31'b0, flush}, 32'h0);

    // Interrupt with Cause.IV=1, BEV=0.
`ifdef EXC_VEC_IV_EN
    iv_expect = 32'h8000_0200;
`else
    iv_expect = 32'h8000_0180;
`endif
    cp0_status = 32'h0;
    cp0_cause  = 32'h0080_0000;
    applyStimulus(1'b1, ExcT_Intr, 32'h8000_A000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, ExcT_NoExc, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("intr_code", {27'b0, cp0_exccode}, 32'd0);
    checkOutput("intr_we", {31'b0, cp0_exc_we}, 32'h1);
    tick();
    checkOutput("intr_rpc", redirect_pc, iv_expect);
    finishRedirect();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
